// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage.
//   alu_op_e    : ALU opcode encoding (11 is reserved and never writes back)
//   nzcv_t      : flag bundle in architectural {N,Z,C,V} order
//   res_entry_t : one buffered ALU result with its destination and flags
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_ADDR_W-1:0] rd;
    logic                  we;
    nzcv_t                 flags;
    logic                  set_flags;
  } res_entry_t;

endpackage

// File: rtl/alu_skid_fifo.sv
// Two-entry FIFO between the ALU and writeback.
//   clk, rst_n     : clock, synchronous active-low reset
//   i_push_valid   : upstream has an entry; taken when o_push_ready is high
//   o_push_ready   : registered "not full"; depends only on the stored count
//   i_push_data    : entry to enqueue
//   o_pop_valid    : head entry valid
//   i_pop_ready    : downstream takes the head this cycle
//   o_pop_data     : head entry, forced to zero while empty
module alu_skid_fifo #(
  parameter type T_ENTRY = alu_pkg::res_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push_valid,
  output logic   o_push_ready,
  input  T_ENTRY i_push_data,
  output logic   o_pop_valid,
  input  logic   i_pop_ready,
  output T_ENTRY o_pop_data
);

  T_ENTRY     r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       r_in_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push = i_push_valid & r_in_ready;
  assign w_pop  = (r_count != 2'd0) & i_pop_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_nxt;
      // Registered from the next count, so a retire while full only
      // reopens the input on the following cycle.
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_push_ready = r_in_ready;
  assign o_pop_valid  = (r_count != 2'd0);
  assign o_pop_data   = o_pop_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/alu_result_stage.sv
// Execute->writeback stage behind the integer ALU. Buffers results in a
// 2-entry FIFO and, at retire, updates the architectural NZCV register and
// the sticky saturation flag / saturating event counter.
//   clk, rst_n                   : clock, synchronous active-low reset
//   in_valid/in_ready            : ALU result handshake
//   in_data, in_c/n/v/z          : ALU result and flags
//   in_opcode, in_rd, in_set_flags : op type, destination, flag-update enable
//   out_valid/out_ready          : writeback handshake
//   out_data, out_rd, out_we     : head result, destination, write enable
//   flags_nzcv                   : architectural {N,Z,C,V}
//   sat_sticky, sat_count, clr_sat : saturation status and its clear
// DATA_WIDTH and REG_ADDR_W must match the widths fixed in alu_pkg.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_W,
  parameter int REG_ADDR_W = ALU_ADDR_W,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_c,
  input  logic                  in_n,
  input  logic                  in_v,
  input  logic                  in_z,
  input  logic [1:0]            in_opcode,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_set_flags,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic [3:0]            flags_nzcv,
  output logic                  sat_sticky,
  output logic [CNT_W-1:0]      sat_count,
  input  logic                  clr_sat
);

  res_entry_t       w_in_entry;
  res_entry_t       w_head;
  logic             w_retire;
  logic             w_flag_upd;
  logic             w_sat_evt;
  logic [CNT_W-1:0] w_cnt_inc;

  nzcv_t            r_flags;
  logic             r_sat_sticky;
  logic [CNT_W-1:0] r_sat_count;

  always_comb begin
    w_in_entry           = '0;
    w_in_entry.data      = in_data;
    w_in_entry.rd        = in_rd;
    w_in_entry.we        = (alu_op_e'(in_opcode) != OP_RSV);
    w_in_entry.flags     = '{n: in_n, z: in_z, c: in_c, v: in_v};
    w_in_entry.set_flags = in_set_flags;
  end

  alu_skid_fifo #(
    .T_ENTRY (res_entry_t)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push_valid (in_valid),
    .o_push_ready (in_ready),
    .i_push_data  (w_in_entry),
    .o_pop_valid  (out_valid),
    .i_pop_ready  (out_ready),
    .o_pop_data   (w_head)
  );

  assign out_data = w_head.data;
  assign out_rd   = w_head.rd;
  assign out_we   = w_head.we;

  // we doubles as "not reserved": reserved entries never touch flags or counter.
  assign w_retire   = out_valid & out_ready;
  assign w_flag_upd = w_retire & w_head.we & w_head.set_flags;
  assign w_sat_evt  = w_retire & w_head.we & w_head.flags.v;
  assign w_cnt_inc  = (r_sat_count == {CNT_W{1'b1}}) ? r_sat_count
                                                      : r_sat_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags      <= '0;
      r_sat_sticky <= 1'b0;
      r_sat_count  <= '0;
    end else begin
      if (w_flag_upd) r_flags <= w_head.flags;
      // A saturating retire coincident with a clear counts as the first
      // event after the clear.
      if (clr_sat) begin
        r_sat_sticky <= w_sat_evt;
        r_sat_count  <= w_sat_evt ? CNT_W'(1) : '0;
      end else if (w_sat_evt) begin
        r_sat_sticky <= 1'b1;
        r_sat_count  <= w_cnt_inc;
      end
    end
  end

  assign flags_nzcv = r_flags;
  assign sat_sticky = r_sat_sticky;
  assign sat_count  = r_sat_count;

endmodule
